// File: rtl/counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_ctrl_pkg
//  Description : Shared types and default sizes for the counter sweep
//                sequencer (state encoding, default widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_ctrl_pkg;

    // Default widths: increment/start/step, step count/index, dwell count.
    localparam int unsigned c_WIDTH   = 32;
    localparam int unsigned c_NSTEP_W = 16;
    localparam int unsigned c_DWELL_W = 16;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage : counter_ctrl_pkg
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dwell_timer
//  Description : Repeating hold timer. A load captures the dwell length
//                (0 is treated as 1); while enabled, o_expire pulses for one
//                cycle every D cycles, the first pulse D cycles after load.
//  Ports       : clk, reset    - clock, synchronous active-high reset
//                i_load        - capture i_dwell and restart the period
//                i_en          - count enable
//                i_dwell       - dwell length in cycles
//                o_expire      - last cycle of the current period
//  Revision    : 1.0 - initial release
// ============================================================================
module dwell_timer
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned DWELL_W = c_DWELL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic               i_en,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic               o_expire
);

    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] r_len_m1;
    logic [DWELL_W-1:0] w_len_m1;

    // A zero dwell behaves as a one-cycle dwell.
    assign w_len_m1 = (i_dwell == '0) ? '0 : (i_dwell - 1'b1);

    // Counter value 0 marks the final cycle of a period.
    assign o_expire = i_en && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_len_m1 <= '0;
        end else if (i_load) begin
            r_cnt    <= w_len_m1;
            r_len_m1 <= w_len_m1;
        end else if (i_en) begin
            if (r_cnt == '0) begin
                r_cnt <= r_len_m1;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule : dwell_timer
`default_nettype wire

// File: rtl/counter_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : counter_sweep_ctrl
//  Description : Drives the free-running counter's increment and active-low
//                reset through a programmed linear sweep: start value, then
//                N additions of step, each value held for a dwell time.
//                Optional looping; abort returns to IDLE with incr cleared.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                cfg_valid_i/ready - configuration handshake (ready in IDLE)
//                cfg_start/step/nsteps/dwell/loop_i - sweep configuration
//                abort_i           - terminate the sweep
//                incr_o            - counter increment (registered)
//                counter_resetn_o  - counter reset, low in LOAD (registered)
//                busy_o            - high in LOAD and RUN
//                step_strobe_o     - first cycle of each new value in RUN
//                done_o            - normal completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_sweep_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = c_WIDTH,
    parameter int unsigned NSTEP_W = c_NSTEP_W,
    parameter int unsigned DWELL_W = c_DWELL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [WIDTH-1:0]   cfg_start_i,
    input  logic [WIDTH-1:0]   cfg_step_i,
    input  logic [NSTEP_W-1:0] cfg_nsteps_i,
    input  logic [DWELL_W-1:0] cfg_dwell_i,
    input  logic               cfg_loop_i,
    input  logic               abort_i,
    output logic [WIDTH-1:0]   incr_o,
    output logic               counter_resetn_o,
    output logic               busy_o,
    output logic               step_strobe_o,
    output logic               done_o
);

    state_t r_state;
    state_t w_state_nxt;

    // Latched configuration.
    logic [WIDTH-1:0]   r_start;
    logic [WIDTH-1:0]   r_step;
    logic [NSTEP_W-1:0] r_nsteps;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_loop;

    logic [NSTEP_W-1:0] r_idx;
    logic [WIDTH-1:0]   r_incr;
    logic               r_resetn;
    logic               r_busy;
    logic               r_strobe;
    logic               r_done;
    logic               r_ready;

    logic [NSTEP_W-1:0] w_idx_nxt;
    logic [WIDTH-1:0]   w_incr_nxt;
    logic               w_strobe_nxt;
    logic               w_done_nxt;
    logic               w_latch;
    logic               w_timer_load;
    logic               w_timer_en;
    logic               w_expire;

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_timer_load),
        .i_en     (w_timer_en),
        .i_dwell  (r_dwell),
        .o_expire (w_expire)
    );

    // Next-state and next-output logic. Outputs are registered from these
    // values, so each output reflects the state entered on that edge.
    always_comb begin
        w_state_nxt  = r_state;
        w_incr_nxt   = r_incr;
        w_idx_nxt    = r_idx;
        w_strobe_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        w_latch      = 1'b0;
        w_timer_load = 1'b0;
        w_timer_en   = 1'b0;

        if (abort_i) begin
            w_state_nxt = ST_IDLE;
            w_incr_nxt  = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cfg_valid_i) begin
                        w_latch     = 1'b1;
                        w_state_nxt = ST_LOAD;
                        w_incr_nxt  = cfg_start_i;
                        w_idx_nxt   = '0;
                    end
                end
                ST_LOAD: begin
                    // Timer starts its first period in the first RUN cycle.
                    w_timer_load = 1'b1;
                    w_state_nxt  = ST_RUN;
                end
                ST_RUN: begin
                    w_timer_en = 1'b1;
                    if (w_expire) begin
                        if (r_idx < r_nsteps) begin
                            w_incr_nxt   = r_incr + r_step;
                            w_idx_nxt    = r_idx + 1'b1;
                            w_strobe_nxt = 1'b1;
                        end else if (r_loop) begin
                            // Restart without clearing the counter.
                            w_incr_nxt   = r_start;
                            w_idx_nxt    = '0;
                            w_strobe_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_start  <= '0;
            r_step   <= '0;
            r_nsteps <= '0;
            r_dwell  <= '0;
            r_loop   <= 1'b0;
            r_idx    <= '0;
            r_incr   <= '0;
            r_resetn <= 1'b0;
            r_busy   <= 1'b0;
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_incr   <= w_incr_nxt;
            r_resetn <= (w_state_nxt != ST_LOAD);
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_ready  <= (w_state_nxt == ST_IDLE);
            r_strobe <= w_strobe_nxt;
            r_done   <= w_done_nxt;
            if (w_latch) begin
                r_start  <= cfg_start_i;
                r_step   <= cfg_step_i;
                r_nsteps <= cfg_nsteps_i;
                r_dwell  <= cfg_dwell_i;
                r_loop   <= cfg_loop_i;
            end
        end
    end

    assign cfg_ready_o      = r_ready;
    assign incr_o           = r_incr;
    assign counter_resetn_o = r_resetn;
    assign busy_o           = r_busy;
    assign step_strobe_o    = r_strobe;
    assign done_o           = r_done;

endmodule : counter_sweep_ctrl
`default_nettype wire

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
- Sequencer that drives the increment input and the active-low reset of the free-running counter.
- Steps the increment through a programmed linear sweep: a start value, then N additions of a step value, each held for a programmable dwell time.
- Optional continuous looping; abort supported.
- Sits between the host configuration interface and the counter instance. Owns the counter's incr_i and resetn.

Parameters:
- WIDTH, 32, width of increment, start and step values (matches counter incr_i).
- NSTEP_W, 16, width of the step count and step index.
- DWELL_W, 16, width of the dwell-cycle count.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- cfg_valid_i  in  1  configuration/start request.
- cfg_ready_o  out  1  high only in IDLE; a transfer occurs when valid and ready are both high.
- cfg_start_i  in  WIDTH  first increment value.
- cfg_step_i  in  WIDTH  value added per step; two's-complement, so downward sweeps are allowed.
- cfg_nsteps_i  in  NSTEP_W  number of step updates after the start value.
- cfg_dwell_i  in  DWELL_W  cycles each value is held; 0 is treated as 1.
- cfg_loop_i  in  1  1 = restart from the start value after the last dwell.
- abort_i  in  1  terminate the sweep.
- incr_o  out  WIDTH  registered; drives counter incr_i.
- counter_resetn_o  out  1  registered; drives counter resetn.
- busy_o  out  1  high in LOAD and RUN.
- step_strobe_o  out  1  one-cycle pulse in the first cycle each new incr_o value is valid, except the LOAD cycle.
- done_o  out  1  one-cycle pulse at normal (non-loop, non-abort) completion.

Behaviour:
- Reset (synchronous, cycle after reset high):
  - incr_o=0, counter_resetn_o=0, busy_o=0, step_strobe_o=0, done_o=0.
  - State = IDLE; latched configuration cleared.
- All outputs are registered.
- States: IDLE, LOAD, RUN.
- IDLE:
  - cfg_ready_o=1, counter_resetn_o=1.
  - incr_o holds its last value (0 after reset or abort).
  - On handshake at cycle T0, latch all cfg_* inputs and go to LOAD.
- LOAD (exactly 1 cycle, T1):
  - incr_o=start, counter_resetn_o=0 (clears the counter), busy_o=1.
  - Dwell timer is loaded; next state RUN.
- RUN (from T2):
  - counter_resetn_o=1.
  - Dwell timer counts D = max(cfg_dwell,1) cycles per value.
  - At the end of each dwell with step_idx < nsteps: incr_o += step (modulo 2^WIDTH, wrap with no saturation), step_idx++, step_strobe_o pulses.
  - Value k (k ≥ 1) appears at cycle T2 + k*D. The start value is therefore visible for D+1 cycles, including LOAD.
- End of the last dwell (cycle T2+(N+1)*D):
  - loop=0: state IDLE, done_o=1 for one cycle, busy_o=0, incr_o keeps its final value.
  - loop=1: incr_o=start, step_idx=0, step_strobe_o pulses, remain in RUN. The counter is not cleared, and done_o is not asserted.
- nsteps=0: a single start value for D cycles of RUN, then done (or restart if looping).
- abort_i:
  - In any state, the next state is IDLE, incr_o=0, counter_resetn_o=1, busy_o=0, no done_o.
  - Abort in IDLE coinciding with cfg_valid_i: abort wins and nothing is latched.
  - Abort in the LOAD cycle is handled the same way.
- cfg_* inputs are ignored outside IDLE.
- reset has priority over abort, and abort over everything else.

Decomposition:
- Package counter_ctrl_pkg:
  - State enum (IDLE, LOAD, RUN).
  - Default constants WIDTH=32, NSTEP_W=16, DWELL_W=16.
- Sub-module dwell_timer:
  - Inputs: load and a DWELL_W length (0→1).
  - Outputs: a one-cycle expire pulse every D cycles while enabled.
  - Reused for the per-value hold.

Test Plan:
- Reset:
  - Stimulus: reset high for 3 cycles, then low with cfg_valid_i=0.
  - Required: incr_o=0, busy_o=0, cfg_ready_o=1; counter_resetn_o=0 during reset and 1 afterwards.
- Basic sweep:
  - Stimulus: start=2, step=2, nsteps=1, dwell=5, loop=0, handshake at T0.
  - Required: incr_o=2 during T1..T6, 4 during T7..T11, step_strobe_o at T7, done_o at T12, busy_o low from T12, counter_resetn_o=0 only at T1.
- Wrap:
  - Stimulus: start=0xFFFFFFFE, step=4, nsteps=2, dwell=1.
  - Required: incr_o sequence 0xFFFFFFFE, 0x00000002, 0x00000006, then done.
- Loop:
  - Stimulus: start=4, step=4, nsteps=2, dwell=2, loop=1.
  - Required: repeating 4,4,4 (LOAD+2), 8,8, 12,12, 4,4, …; step_strobe_o on every value change including the 12→4 restart; done_o never asserted; counter_resetn_o low only at T1.
- Abort:
  - Stimulus: abort_i mid-RUN of the basic sweep at T9.
  - Required: at T10 incr_o=0, busy_o=0, cfg_ready_o=1, no done_o.
  - Second check: abort_i and cfg_valid_i together in IDLE → no LOAD occurs.
- Edge values:
  - Stimulus: dwell=0, nsteps=0, start=7.
  - Required: incr_o=7 at T1 and T2, done_o at T3.
